// File: rtl/piano_pkg.sv
// Shared piano datapath definitions: note codes, half-period table and
// detector FSM states.
package piano_pkg;

    typedef enum logic [2:0] {
        DO4  = 3'd0,
        RE4  = 3'd1,
        MI4  = 3'd2,
        FA4  = 3'd3,
        SOL4 = 3'd4,
        LA4  = 3'd5,
        SI4  = 3'd6,
        DO5  = 3'd7
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } det_state_t;

    localparam int unsigned NOTE_COUNT = 8;

    // Half-periods in 100 MHz cycles, also used by the tone generator.
    function automatic int unsigned half_period(input int unsigned idx);
        int unsigned hp;
        case (idx)
            0:       hp = 191113;
            1:       hp = 170263;
            2:       hp = 151687;
            3:       hp = 143173;
            4:       hp = 127553;
            5:       hp = 113637;
            6:       hp = 101239;
            default: hp = 95557;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/tone_sync.sv
// Two-flop synchronizer for the asynchronous tone input plus a third flop
// that turns its rising edge into a one-cycle pulse.
module tone_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic tone_in,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], tone_in};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square-wave tone and decodes it into a note code,
// locking after two consecutive matching periods.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no reference edge yet (after reset or silence)
// ST_ARMED   | reference edge seen, waiting for a period inside a window
// ST_CONFIRM | one matching period seen (cand), waiting for a repeat
// ST_LOCKED  | note is valid, tracking further periods
module note_detector
    import piano_pkg::*;
#(
    parameter int          TOL      = 2000,
    parameter int          TIMEOUT  = 500000,
    parameter int          CNT_W    = 20,
    // Right shift applied to the half-period table for reduced clock rates.
    parameter int unsigned HP_SHIFT = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tone_in,
    output logic [2:0]       note,
    output logic             note_valid,
    output logic             note_strobe,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             tone_edge;
    logic             edge_d;
    logic [CNT_W-1:0] cnt;

    det_state_t state, state_nx;
    note_t      cand, cand_nx;
    note_t      note_q, note_nx;
    logic       valid_nx;
    logic       strobe_nx;
    logic       timeout;

    logic [NOTE_COUNT-1:0] in_win;
    logic                  hit;
    note_t                 hit_code;

    tone_sync u_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .tone_in (tone_in),
        .rise    (tone_edge)
    );

    // Period counter; edge_d marks the cycle in which period holds a fresh value.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            period <= '0;
            edge_d <= 1'b0;
        end else begin
            edge_d <= tone_edge;
            if (tone_edge) begin
                period <= cnt;
                cnt    <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NOTE_COUNT; k++) begin : g_win
        localparam int unsigned NOM_FULL = 2 * (half_period(unsigned'(k)) >> HP_SHIFT);
        localparam logic [CNT_W-1:0] NOM = NOM_FULL[CNT_W-1:0];
        localparam logic [CNT_W-1:0] LO  = NOM - TOL_C;
        localparam logic [CNT_W-1:0] HI  = NOM + TOL_C;
        assign in_win[k] = (period >= LO) && (period <= HI);
    end

    // Overlapping windows resolve to the lowest code, so scan downwards.
    always_comb begin
        hit      = 1'b0;
        hit_code = DO4;
        for (int k = NOTE_COUNT - 1; k >= 0; k--) begin
            if (in_win[k]) begin
                hit      = 1'b1;
                hit_code = note_t'(3'(k));
            end
        end
    end

    // A coincident edge restarts the count, so it beats the timeout.
    assign timeout = (cnt == TIMEOUT_C) && !tone_edge;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= DO4;
            note_q      <= DO4;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            state       <= state_nx;
            cand        <= cand_nx;
            note_q      <= note_nx;
            note_valid  <= valid_nx;
            note_strobe <= strobe_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cand_nx   = cand;
        note_nx   = note_q;
        valid_nx  = note_valid;
        strobe_nx = 1'b0;
        if (edge_d) begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    if (hit) begin
                        cand_nx  = hit_code;
                        state_nx = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!hit) begin
                        state_nx = ST_ARMED;
                    end else if (hit_code == cand) begin
                        state_nx  = ST_LOCKED;
                        note_nx   = hit_code;
                        valid_nx  = 1'b1;
                        strobe_nx = 1'b1;
                    end else begin
                        cand_nx = hit_code;
                    end
                end
                ST_LOCKED: begin
                    if (!hit) begin
                        state_nx = ST_ARMED;
                        valid_nx = 1'b0;
                    end else if (hit_code != note_q) begin
                        cand_nx  = hit_code;
                        state_nx = ST_CONFIRM;
                        valid_nx = 1'b0;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end else if (timeout && state != ST_IDLE) begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
        end
    end

    assign note = note_q;

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector: directed table, corner-case
// sequences and randomized periods against a period-history model.
module tb_note_detector;
    import piano_pkg::*;

    localparam int TOL_T     = 5;
    localparam int TIMEOUT_T = 977;
    localparam int CNT_W_T   = 20;
    localparam int SHIFT_T   = 9;
    // Clock edges from a tone rise until the edge is registered by the counter.
    localparam int EDGE_LAT  = 3;

    logic               clk_in  = 1'b0;
    logic               rst     = 1'b1;
    logic               tone_in = 1'b0;
    logic [2:0]         note;
    logic               note_valid;
    logic               note_strobe;
    logic [CNT_W_T-1:0] period;

    note_detector #(
        .TOL      (TOL_T),
        .TIMEOUT  (TIMEOUT_T),
        .CNT_W    (CNT_W_T),
        .HP_SHIFT (SHIFT_T)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tone_in     (tone_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_strobe (note_strobe),
        .period      (period)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: validity depends only on the last two periods since arming.
    int r      = 0;
    int m_prev = -1;
    int m_valid = 0;
    int m_note = 0;

    typedef struct {
        int gap;
        int v;
        int n;
        int s;
        int st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int gap, input int v, input int n, input int s, input int st);
        vec_t t;
        t.gap = gap; t.v = v; t.n = n; t.s = s; t.st = st;
        return t;
    endfunction

    function automatic int nominal(input int k);
        int hp;
        case (k)
            0:       hp = 191113;
            1:       hp = 170263;
            2:       hp = 151687;
            3:       hp = 143173;
            4:       hp = 127553;
            5:       hp = 113637;
            6:       hp = 101239;
            default: hp = 95557;
        endcase
        return 2 * (hp >> SHIFT_T);
    endfunction

    function automatic int classify(input int p);
        for (int k = 0; k < 8; k++) begin
            if (p >= nominal(k) - TOL_T && p <= nominal(k) + TOL_T) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic first_rise();
        tone_in = 1'b0;
        repeat (2) @(negedge clk_in);
        tone_in = 1'b1;
        r = cyc;
        m_prev = -1;
        m_valid = 0;
        repeat (EDGE_LAT + 1) @(posedge clk_in);
        #1;
        chk("first_valid", int'(note_valid), 0);
        chk("first_strobe", int'(note_strobe), 0);
        chk("first_note", int'(note), m_note);
    endtask

    task automatic step(input int gap);
        int c;
        int e_strobe;
        while (cyc < r + gap / 2) @(negedge clk_in);
        tone_in = 1'b0;
        while (cyc < r + gap) @(negedge clk_in);
        tone_in = 1'b1;
        r = cyc;
        e_strobe = 0;
        if (gap > TIMEOUT_T) begin
            m_valid = 0;
            m_prev = -1;
        end else begin
            c = classify(gap);
            if (c >= 0 && c == m_prev) begin
                if (m_valid == 0) e_strobe = 1;
                m_valid = 1;
                m_note = c;
            end else begin
                m_valid = 0;
            end
            m_prev = c;
        end
        repeat (EDGE_LAT + 1) @(posedge clk_in);
        #1;
        chk("valid", int'(note_valid), m_valid);
        chk("note", int'(note), m_note);
        chk("strobe", int'(note_strobe), e_strobe);
        chk("period", int'(period), gap);
    endtask

    logic strobe_prev = 1'b0;
    always @(posedge clk_in) begin
        #1;
        if (strobe_prev) begin
            n_vec++;
            if (note_strobe) begin
                n_err++;
                $display("FAIL strobe_width: got 1 on consecutive cycles, expected 0 (cycle %0d)", cyc);
            end
        end
        strobe_prev = note_strobe;
    end

    initial begin
        int fall_at;
        int k;
        int sel;
        int gap;

        tbl.push_back(mk(0,   0, 0, 0, int'(ST_ARMED)));
        tbl.push_back(mk(746, 0, 0, 0, int'(ST_CONFIRM)));
        tbl.push_back(mk(746, 1, 0, 1, int'(ST_LOCKED)));
        tbl.push_back(mk(746, 1, 0, 0, -1));
        tbl.push_back(mk(442, 0, 0, 0, int'(ST_CONFIRM)));
        tbl.push_back(mk(442, 1, 5, 1, int'(ST_LOCKED)));
        tbl.push_back(mk(442, 1, 5, 0, -1));
        tbl.push_back(mk(592, 0, 5, 0, int'(ST_CONFIRM)));
        tbl.push_back(mk(592, 1, 2, 1, -1));
        tbl.push_back(mk(751, 0, 2, 0, -1));
        tbl.push_back(mk(741, 1, 0, 1, int'(ST_LOCKED)));
        tbl.push_back(mk(752, 0, 0, 0, int'(ST_ARMED)));
        tbl.push_back(mk(752, 0, 0, 0, int'(ST_ARMED)));
        tbl.push_back(mk(752, 0, 0, 0, int'(ST_ARMED)));

        repeat (3) @(negedge clk_in);
        chk("rst_note", int'(note), 0);
        chk("rst_valid", int'(note_valid), 0);
        chk("rst_strobe", int'(note_strobe), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_state", int'(dut.state), int'(ST_IDLE));
        rst = 1'b0;
        repeat (5) @(negedge clk_in);

        foreach (tbl[i]) begin
            if (tbl[i].gap == 0) first_rise();
            else step(tbl[i].gap);
            chk("tbl_valid", int'(note_valid), tbl[i].v);
            chk("tbl_note", int'(note), tbl[i].n);
            chk("tbl_strobe", int'(note_strobe), tbl[i].s);
            if (tbl[i].st >= 0) chk("tbl_state", int'(dut.state), tbl[i].st);
        end

        // Lock Do5, then go silent.
        step(372);
        step(372);
        chk("do5_locked", int'(note_valid), 1);
        @(negedge clk_in);
        tone_in = 1'b0;
        fall_at = -1;
        while (cyc - r < TIMEOUT_T + 50) begin
            @(posedge clk_in);
            #1;
            if (!note_valid) begin
                fall_at = cyc - r;
                break;
            end
        end
        chk("timeout_delay", fall_at, TIMEOUT_T + EDGE_LAT);
        chk("timeout_note", int'(note), 7);
        chk("timeout_state", int'(dut.state), int'(ST_IDLE));
        m_valid = 0;
        m_prev = -1;

        // Re-arm after silence, lock Do4, then an edge exactly at the timeout count.
        step(TIMEOUT_T + 200);
        chk("rearm_state", int'(dut.state), int'(ST_ARMED));
        step(746);
        step(746);
        step(TIMEOUT_T);
        chk("edge_at_timeout_state", int'(dut.state), int'(ST_ARMED));
        step(746);
        step(746);

        // Lock Sol4 and reset in the middle of a period.
        step(498);
        step(498);
        repeat (20) @(posedge clk_in);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_note", int'(note), 0);
        chk("midrst_valid", int'(note_valid), 0);
        chk("midrst_strobe", int'(note_strobe), 0);
        chk("midrst_period", int'(period), 0);
        chk("midrst_state", int'(dut.state), int'(ST_IDLE));
        @(negedge clk_in);
        tone_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        m_note = 0;
        m_valid = 0;
        m_prev = -1;
        repeat (5) @(negedge clk_in);
        first_rise();
        step(498);
        step(498);

        // Randomized periods, biased towards repeating notes so locks happen.
        k = int'($urandom_range(0, 7));
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 9) < 4) k = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 19));
            if (sel == 0) gap = TIMEOUT_T + int'($urandom_range(1, 60));
            else if (sel < 3) gap = int'($urandom_range(300, 900));
            else gap = nominal(k) + int'($urandom_range(0, 2 * TOL_T + 4)) - (TOL_T + 2);
            step(gap);
        end

        repeat (5) @(posedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/note_detector.md
# note_detector

Measures the period of an incoming square-wave tone and decodes it back into the 3-bit note code (Do4..Do5) used by the tone generator. It sits on the receive/analysis side of the piano datapath, consuming the generated tone or an external one. It reports a stable note code once two consecutive matching periods are seen, and drops it on mismatch or silence. `clk_in` is 100 MHz, and the note table counts half-periods at that rate.

## Interface
- `TOL`, 2000: accepted deviation (clk_in cycles, ±) of a measured full period from the nominal one.
- `TIMEOUT`, 500000: cycles without a rising edge before the input is declared silent.
- `CNT_W`, 20: width of the period counter and of `period`.
- `clk_in`  in  1  system clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tone_in`  in  1  asynchronous square-wave tone.
- `note`  out  3  decoded note code: 000 Do4, 001 Re4, 010 Mi4, 011 Fa4, 100 Sol4, 101 La4, 110 Si4, 111 Do5.
- `note_valid`  out  1  high while `note` is locked.
- `note_strobe`  out  1  one-cycle pulse when `note_valid` rises or `note` changes while locked.
- `period`  out  CNT_W  last measured full period in cycles.

## Operation
- `tone_in` passes through a 2-flop synchronizer and a third flop. `edge` = sync2 & ~sync3.
- Counter `cnt`:
  - On `edge`: `period` <= `cnt`, then `cnt` <= 1.
  - Otherwise `cnt` increments and saturates at 2^CNT_W−1.
  - P cycles between edges gives `period` = P.
- Classification of a measured value P:
  - Match for code k when 2·N_k − TOL ≤ P ≤ 2·N_k + TOL, with unsigned CNT_W-bit compares.
  - N_k is the half-period table: 191113, 170263, 151687, 143173, 127553, 113637, 101239, 95557.
  - With the default TOL, the windows do not overlap. If they do overlap, the lowest matching code wins.
  - No window hit means no match.
- FSM states:
  - IDLE: on `edge`, go to ARMED. The first edge yields no period.
  - ARMED: on `edge` with a match, set `cand` <= k and go to CONFIRM. With no match, stay in ARMED.
  - CONFIRM, on `edge`:
    - Match with k == `cand`: go to LOCKED, set `note` <= k, `note_valid` <= 1, pulse `note_strobe`.
    - Match with k ≠ `cand`: set `cand` <= k and stay in CONFIRM.
    - No match: go to ARMED.
  - LOCKED, on `edge`:
    - Match with k == `note`: stay in LOCKED.
    - Match with k ≠ `note`: set `cand` <= k, go to CONFIRM, `note_valid` <= 0.
    - No match: go to ARMED, `note_valid` <= 0.
  - Any non-IDLE state: when `cnt` reaches TIMEOUT without an edge, go to IDLE and set `note_valid` <= 0.
  - `note` holds its last value when not valid.
- If an edge and the timeout occur in the same cycle, the edge wins.

## Timing
- Reset values: `note` = 000, `note_valid` = 0, `note_strobe` = 0, `period` = 0, `cnt` = 0, `cand` = 000, state = IDLE.
- Reset mid-measurement discards everything. After release, the first edge only arms the detector.
- `edge` pulses on the 3rd clk_in rising edge after `tone_in` rises, assuming setup is met.
- `note`, `note_valid` and `note_strobe` update in the cycle after the `edge` pulse (registered classify).
- Minimum lock time: 3 rising edges of `tone_in`, which is 2 full periods, plus 4 cycles.
- `note_strobe` is never high for two consecutive cycles.

## Structure
- Shared package `piano_pkg` holds:
  - The note code typedef (3-bit enum DO4..DO5).
  - The half-period table N_k, shared with the tone generator.
  - The FSM state typedef.
- Sub-module `tone_sync`: 2-flop synchronizer plus rising-edge pulse, reset to 0.
- The counter, classifier and FSM stay in `note_detector`.

## Test plan
- Square wave of period 382226 (half 191113) from reset:
  - `note_valid` = 0 after the 1st and 2nd rising edges.
  - After the 3rd: `note` = 000, `note_valid` = 1, one `note_strobe`, `period` = 382226.
- Locked on La4 (period 227274), switch to Mi4 (303374):
  - The 1st Mi4 edge drops `note_valid`.
  - The next edge relocks with `note` = 010 and one strobe.
- Period 382226 + 2000 locks Do4. Period 382226 + 2001 never sets `note_valid`, and the FSM stays in ARMED.
- Locked Do5, then `tone_in` held low: `note_valid` falls exactly TIMEOUT cycles after the last edge, state returns to IDLE, and `note` stays 111.
- Assert `rst` mid-period while locked on Sol4:
  - All outputs go to reset values immediately.
  - Relock requires 3 more edges.
- Force an edge to arrive on the exact cycle `cnt` == TIMEOUT: no timeout occurs, and the period is classified normally (no match at default parameters, so the FSM goes to ARMED).
